// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix coprocessor read/write paths.
// Holds the sequencer state encoding and the matrix size codes.
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int MIN_DIM = 2;
    localparam int ADDR_W  = 5;

    // size_y code selecting a full-matrix result
    localparam logic [7:0] SIZE_FULL  = 8'd0;
    // byte count of a scalar result
    localparam logic [7:0] SCALAR_LEN = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_HDR,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/matrix_len_calc.sv
// Maps a matrix size code to its result length in bytes.
// Shared with the write path so both ends agree on lengths.
module matrix_len_calc #(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM
) (
    input  logic [7:0] size_x,
    input  logic [7:0] size_y,
    output logic [7:0] len,
    output logic       legal
);
    import matrix_pkg::*;

    // square of size_x for a full result, one byte for a scalar
    always_comb begin
        legal = (size_x >= 8'(MIN_DIM)) && (size_x <= 8'(MAX_DIM));
        len   = 8'd0;
        if (legal) begin
            if (size_y == SIZE_FULL)
                len = 8'(size_x * size_x);
            else
                len = SCALAR_LEN;
        end
    end

endmodule

// File: rtl/matrix_read_data.sv
// Result read-out sequencer: result RAM -> byte stream to the UART TX path.
// Define MATRIX_READ_HEADER_EN to prefix the stream with a length byte.
module matrix_read_data #(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int ADDR_W  = matrix_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [7:0]        size_x,
    input  logic [7:0]        size_y,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [7:0]        mat_data_len
);
    import matrix_pkg::*;

    state_t     state;
    logic [7:0] idx;
    logic [7:0] calc_len;
    logic       calc_legal;

    matrix_len_calc #(
        .MAX_DIM (MAX_DIM)
    ) u_len (
        .size_x (size_x),
        .size_y (size_y),
        .len    (calc_len),
        .legal  (calc_legal)
    );

    // sequencer: all outputs are registered and change on state transitions
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            idx          <= 8'd0;
            o_rd_en      <= 1'b0;
            o_rd_addr    <= '0;
            o_tx_data    <= 8'd0;
            o_tx_valid   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            mat_data_len <= 8'd0;
        end else begin
            o_rd_en <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state        <= ST_CALC;
                        idx          <= 8'd0;
                        o_busy       <= 1'b1;
                        mat_data_len <= calc_len;
                        o_err        <= !calc_legal;
                    end
                end
                ST_CALC: begin
                    if (o_err) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
`ifdef MATRIX_READ_HEADER_EN
                        state      <= ST_HDR;
                        o_tx_data  <= mat_data_len;
                        o_tx_valid <= 1'b1;
`else
                        state     <= ST_READ;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= '0;
`endif
                    end
                end
`ifdef MATRIX_READ_HEADER_EN
                ST_HDR: begin
                    if (i_tx_ready) begin
                        state      <= ST_READ;
                        o_tx_valid <= 1'b0;
                        o_rd_en    <= 1'b1;
                        o_rd_addr  <= '0;
                    end
                end
`endif
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state      <= ST_SEND;
                    o_tx_data  <= i_rd_data;
                    o_tx_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        if ((idx + 8'd1) < mat_data_len) begin
                            state     <= ST_READ;
                            idx       <= idx + 8'd1;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= ADDR_W'(idx + 8'd1);
                        end else begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
